// File: rtl/vx_prbs_pkg.sv
// Stream definition shared by the PRBS generator and checker: FSM states, XNOR tap offsets
// and the next-bit function.
package vx_prbs_pkg;

  typedef enum logic [0:0] {StSearch, StCheck} prbs_state_e;

  // Tap offsets below the top NNUM-bit window of the state.
  localparam int unsigned TapA = 0;
  localparam int unsigned TapB = 2;
  localparam int unsigned TapC = 15;
  localparam int unsigned TapD = 17;

  // Widest supported state; callers zero-extend into this width.
  localparam int unsigned MaxBits = 1024;
  localparam int unsigned IdxW    = $clog2(MaxBits);

  // New bit i of the next word, computed from the pre-shift state s of width nbits.
  function automatic logic prbs_next_bit(input logic [MaxBits-1:0] s, input int unsigned nbits,
                                         input int unsigned nnum, input int unsigned i);
    int unsigned base;
    base = nbits - nnum + i;
    return ~(s[IdxW'(base - TapA)] ^ s[IdxW'(base - TapB)] ^
             s[IdxW'(base - TapC)] ^ s[IdxW'(base - TapD)]);
  endfunction

endpackage

// File: rtl/vx_prbs_step.sv
// Combinational PRBS stepper: predicts the next NNUM stream bits and the shifted state.
module vx_prbs_step
  import vx_prbs_pkg::*;
#(
  parameter int unsigned NBITS = 168,
  parameter int unsigned NNUM  = 2
) (
  input  logic [NBITS-1:0] state,
  output logic [NNUM-1:0]  bits,
  output logic [NBITS-1:0] next_state
);

  for (genvar g = 0; g < NNUM; g++) begin : g_bit
    assign bits[g] = prbs_next_bit(MaxBits'(state), NBITS, NNUM, g);
  end

  assign next_state = {state[NBITS-NNUM-1:0], bits};

endmodule

// File: rtl/vx_prbs_checker.sv
// Self-synchronising XNOR-LFSR stream checker with lock tracking and saturating error counter.
// Define VX_PRBS_CHK_BITERR_EN to count mismatching bits instead of mismatching beats.
module vx_prbs_checker
  import vx_prbs_pkg::*;
#(
  parameter int unsigned NBITS       = 168,
  parameter int unsigned NNUM        = 2,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [NNUM-1:0]  in_data,
  input  logic             err_clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned LockBeats = (NBITS + NNUM - 1) / NNUM;
  localparam int unsigned BeatW     = $clog2(LockBeats + 1);
  localparam int unsigned MissW     = $clog2(LOSS_THRESH + 1);
`ifdef VX_PRBS_CHK_BITERR_EN
  localparam int unsigned IncW      = $clog2(NNUM + 1);
`else
  localparam int unsigned IncW      = 1;
`endif

  prbs_state_e      state_q, state_d;
  logic [NBITS-1:0] s_q, s_d;
  logic [BeatW-1:0] beat_q, beat_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [NNUM-1:0]  pred_bits;
  logic [NBITS-1:0] pred_state;
  logic [NNUM-1:0]  mismatch;
  logic             beat_err;
  logic [IncW-1:0]  inc;
  logic [CNT_W-1:0] count_base;
  logic [CNT_W:0]   count_sum;

  vx_prbs_step #(
    .NBITS(NBITS),
    .NNUM (NNUM)
  ) u_step (
    .state     (s_q),
    .bits      (pred_bits),
    .next_state(pred_state)
  );

  assign mismatch = pred_bits ^ in_data;
  assign beat_err = in_valid && (state_q == StCheck) && (|mismatch);

`ifdef VX_PRBS_CHK_BITERR_EN
  assign inc = beat_err ? IncW'($countones(mismatch)) : '0;
`else
  assign inc = beat_err;
`endif

  // Clear takes effect before the same-cycle increment.
  assign count_base = err_clear ? '0 : count_q;
  assign count_sum  = {1'b0, count_base} + (CNT_W + 1)'(inc);

  always_comb begin
    count_d = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
    pulse_d = beat_err;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    beat_d  = beat_q;
    miss_d  = miss_q;
    if (in_valid) begin
      unique case (state_q)
        StSearch: begin
          s_d = {s_q[NBITS-NNUM-1:0], in_data};
          if (beat_q == BeatW'(LockBeats - 1)) begin
            beat_d  = '0;
            state_d = StCheck;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
        StCheck: begin
          // Once locked the local LFSR free-runs; received data never re-enters it.
          s_d = pred_state;
          if (|mismatch) begin
            if (miss_q == MissW'(LOSS_THRESH - 1)) begin
              miss_d  = '0;
              beat_d  = '0;
              state_d = StSearch;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StSearch;
      s_q     <= '0;
      beat_q  <= '0;
      miss_q  <= '0;
      pulse_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      beat_q  <= beat_d;
      miss_q  <= miss_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
    end
  end

  assign locked    = (state_q == StCheck);
  assign err_pulse = pulse_q;
  assign err_count = count_q;

endmodule

// File: tb/tb_vx_prbs_checker.sv
// Bench for vx_prbs_checker: reference generator plus a behavioural checker model compared
// every cycle, with directed phases and a randomized phase.
module tb_vx_prbs_checker;

  localparam int unsigned NB = 32;
  localparam int unsigned NN = 2;
  localparam int unsigned LT = 4;
  localparam int unsigned CW = 8;
  localparam int LockBeats  = 16;
  localparam int CountMax   = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [NN-1:0] in_data;
  logic          err_clear;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vx_prbs_checker #(
    .NBITS      (NB),
    .NNUM       (NN),
    .LOSS_THRESH(LT),
    .CNT_W      (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .err_clear(err_clear),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  // Reference generator state.
  bit [31:0] gs;

  // Checker model: lock flag, local stream state, run counters.
  bit        m_locked;
  bit        m_pulse;
  int        m_count;
  int        m_beats;
  int        m_miss;
  bit [31:0] ms;

  function automatic bit [1:0] prbs_word(input bit [31:0] s);
    bit [1:0] w;
    w[0] = ~(s[30] ^ s[28] ^ s[15] ^ s[13]);
    w[1] = ~(s[31] ^ s[29] ^ s[16] ^ s[14]);
    return w;
  endfunction

  task automatic gen_word(output bit [1:0] w);
    w  = prbs_word(gs);
    gs = {gs[29:0], w};
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input bit rst, input bit v, input bit [1:0] d, input bit clr);
    bit [1:0] p;
    bit [1:0] mm;
    int       add;
    if (rst) begin
      m_locked = 0; m_pulse = 0; m_count = 0; m_beats = 0; m_miss = 0; ms = '0;
      return;
    end
    add = 0;
    m_pulse = 0;
    if (v) begin
      if (!m_locked) begin
        ms = {ms[29:0], d};
        m_beats++;
        if (m_beats == LockBeats) begin
          m_locked = 1;
          m_beats  = 0;
        end
      end else begin
        p  = prbs_word(ms);
        ms = {ms[29:0], p};
        mm = p ^ d;
        if (mm != 2'b00) begin
          m_pulse = 1;
`ifdef VX_PRBS_CHK_BITERR_EN
          add = int'(mm[0]) + int'(mm[1]);
`else
          add = 1;
`endif
          m_miss++;
          if (m_miss == LT) begin
            m_locked = 0;
            m_miss   = 0;
            m_beats  = 0;
          end
        end else begin
          m_miss = 0;
        end
      end
    end
    m_count = (clr ? 0 : m_count) + add;
    if (m_count > CountMax) m_count = CountMax;
  endtask

  // One clock: drive, clock, advance model, compare all outputs.
  task automatic step(input bit rst, input bit v, input bit [1:0] d, input bit clr);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    err_clear = clr;
    @(posedge clk);
    model_update(rst, v, d, clr);
    #1;
    chk("locked", int'(locked), int'(m_locked));
    chk("err_pulse", int'(err_pulse), int'(m_pulse));
    chk("err_count", int'(err_count), m_count);
  endtask

  task automatic beat(input bit [1:0] corrupt, input bit clr);
    bit [1:0] w;
    gen_word(w);
    step(1'b0, 1'b1, w ^ corrupt, clr);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'b0);
  endtask

  initial begin
    bit [31:0] s_tmp;
    int        r;
    int        burst;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; err_clear = 1'b0;
    gs = 32'h1234_5678;

    // Hand-derived words pin the stream model.
    s_tmp = 32'h1234_5678; chk("pin_seed", int'(prbs_word(s_tmp)), 0);
    s_tmp = 32'hFFFF_FFFF; chk("pin_ones", int'(prbs_word(s_tmp)), 3);
    s_tmp = 32'h4000_0000; chk("pin_bit30", int'(prbs_word(s_tmp)), 2);

    repeat (3) step(1'b1, 1'b0, 2'b00, 1'b0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_count", int'(err_count), 0);

    // Clean stream: lock exactly after the 16th valid beat.
    for (int i = 0; i < 200; i++) begin
      beat(2'b00, 1'b0);
      if (i == LockBeats - 2) chk("lock_early", int'(locked), 0);
      if (i == LockBeats - 1) chk("lock_rise", int'(locked), 1);
    end
    chk("clean_count", int'(err_count), 0);

    // Single flipped bit.
    beat(2'b01, 1'b0);
    chk("single_pulse", int'(err_pulse), 1);
    chk("single_count", int'(err_count), 1);
    beat(2'b00, 1'b0);
    chk("single_pulse_end", int'(err_pulse), 0);
    chk("single_lock_held", int'(locked), 1);

    // Clear, then four consecutive corrupted beats drop lock; resync on clean data.
    beat(2'b00, 1'b1);
    chk("clear_count", int'(err_count), 0);
    for (int i = 0; i < 3; i++) beat(2'b01, 1'b0);
    chk("loss_early", int'(locked), 1);
    beat(2'b01, 1'b0);
    chk("loss_fall", int'(locked), 0);
    chk("loss_count", int'(err_count), 4);
    for (int i = 0; i < LockBeats; i++) begin
      beat(2'b00, 1'b0);
      if (i == LockBeats - 2) chk("relock_early", int'(locked), 0);
    end
    chk("relock", int'(locked), 1);
    repeat (10) beat(2'b00, 1'b0);
    chk("relock_count", int'(err_count), 4);

    // Reset while checking.
    step(1'b1, 1'b1, 2'b11, 1'b0);
    chk("midrst_locked", int'(locked), 0);
    chk("midrst_count", int'(err_count), 0);
    chk("midrst_pulse", int'(err_pulse), 0);

    // Valid gaps on a fresh seed.
    gs = $urandom;
    for (int i = 0; i < 2 * LockBeats; i++) begin
      if (i % 2 == 1) idle();
      else beat(2'b00, 1'b0);
    end
    chk("gap_lock", int'(locked), 1);
    repeat (20) beat(2'b00, 1'b0);
    chk("gap_count", int'(err_count), 0);

    // Three errors per four beats keeps lock while driving the counter into saturation.
    for (int i = 0; i < 400; i++) beat((i % 4 == 3) ? 2'b00 : 2'b01, 1'b0);
    chk("sat_count", int'(err_count), CountMax);
    chk("sat_locked", int'(locked), 1);
    beat(2'b01, 1'b1);
    chk("clear_with_err", int'(err_count), 1);

    // Randomized traffic: gaps, corruption bursts, clears, resets, reseeds.
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        gs = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else if (r < 50) begin
        idle();
      end else begin
        if (r < 54 && burst == 0) burst = int'($urandom_range(2, 6));
        if (r == 54) gs = $urandom;
        if (burst > 0) begin
          burst--;
          beat(2'($urandom_range(1, 3)), 1'($urandom_range(0, 19) == 0));
        end else begin
          beat(($urandom_range(0, 99) < 3) ? 2'($urandom_range(1, 3)) : 2'b00,
               1'($urandom_range(0, 49) == 0));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
